// File: rtl/rast_iter_pkg.sv
// rtl/rast_iter_pkg.sv - shared types and helpers for the bounding-box sample iterator
package rast_iter_pkg;

  localparam int LANES = 2;

  typedef enum logic {
    WAIT_STATE = 1'b0,
    TEST_STATE = 1'b1
  } iter_state_t;

  // One-hot subsample mode to grid pitch; MSAA1 is a whole pixel.
  function automatic logic [31:0] step_from_subsample(input logic [3:0] sub, input int radix);
    logic [31:0] s;
    s = 32'd0;
    if (sub[3])      s = 32'd1 << radix;
    else if (sub[2]) s = 32'd1 << (radix - 1);
    else if (sub[1]) s = 32'd1 << (radix - 2);
    else if (sub[0]) s = 32'd1 << (radix - 3);
    return s;
  endfunction

endpackage

// File: rtl/sample_lane_gen.sv
// rtl/sample_lane_gen.sv - combinational lane positions and x-bound valids for one group
module sample_lane_gen
  import rast_iter_pkg::*;
#(
  parameter int SIGFIG  = 24,
  parameter int SAMPLES = LANES
) (
  input  logic signed [SIGFIG-1:0]                  x0,
  input  logic signed [SIGFIG-1:0]                  y,
  input  logic signed [SIGFIG-1:0]                  step,
  input  logic signed [SIGFIG-1:0]                  ur_x,
  output logic signed [SAMPLES-1:0][1:0][SIGFIG-1:0] pos,
  output logic        [SAMPLES-1:0]                 valid
);

  localparam int W = SIGFIG + 4;

  for (genvar i = 0; i < SAMPLES; i++) begin : g_lane
    logic signed [W-1:0] xw;
    // Widened so the bound compare is not fooled by wrap near the coordinate limit.
    assign xw        = W'(x0) + W'(i) * W'(step);
    assign pos[i][0] = xw[SIGFIG-1:0];
    assign pos[i][1] = y;
    assign valid[i]  = (xw <= W'(ur_x));
  end

endmodule

// File: rtl/sample_iterator.sv
// rtl/sample_iterator.sv - raster walk of a triangle bbox at subsample pitch; optional SAMPLE_ITER_PERF_CNT_EN counters
module sample_iterator
  import rast_iter_pkg::*;
#(
  parameter int SIGFIG  = 24,
  parameter int RADIX   = 10,
  parameter int VERTS   = 3,
  parameter int AXIS    = 3,
  parameter int COLORS  = 3,
  parameter int SAMPLES = LANES
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S,
  input  logic                                        validTri_R13H,
  input  logic        [3:0]                           subSample_RnnnnU,
  output logic                                        halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  output logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U,
  output logic signed [SAMPLES-1:0][1:0][SIGFIG-1:0]    sample_R14S,
  output logic        [SAMPLES-1:0]                   validSamp_R14H
`ifdef SAMPLE_ITER_PERF_CNT_EN
  ,
  output logic        [31:0]                          iterCycles_R14U,
  output logic        [31:0]                          iterTris_R14U
`endif
);

  localparam int W = SIGFIG + 4;

  iter_state_t state, next_state;
  logic signed [1:0][1:0][SIGFIG-1:0] box_q, g_box;
  logic signed [SIGFIG-1:0] x0_q, y_q, step;
  logic signed [SIGFIG-1:0] g_llx, g_lly, g_urx, g_ury;
  logic signed [SIGFIG-1:0] tx, ty, gx, gy;
  logic signed [W-1:0]      span, c_nx;
  logic                     accept, emit, c_wrap, g_degen, g_last, row_ok;
  logic signed [SAMPLES-1:0][1:0][SIGFIG-1:0] lane_pos;
  logic        [SAMPLES-1:0]                 lane_valid;

  assign step   = SIGFIG'(step_from_subsample(subSample_RnnnnU, RADIX));
  assign span   = W'(step) * W'(SAMPLES);
  assign accept = (state == WAIT_STATE) && validTri_R13H && halt_RnnnnL;
  assign emit   = accept || (state == TEST_STATE);

  // On acceptance the fresh box drives the walk; afterwards the latched copy does.
  assign g_box = accept ? box_R13S : box_q;
  assign g_llx = g_box[0][0];
  assign g_lly = g_box[0][1];
  assign g_urx = g_box[1][0];
  assign g_ury = g_box[1][1];

  // Advance from the group currently on R14.
  assign c_nx   = W'(x0_q) + span;
  assign c_wrap = c_nx > W'(g_urx);
  assign tx     = c_wrap ? g_llx : c_nx[SIGFIG-1:0];
  assign ty     = c_wrap ? y_q + step : y_q;

  assign gx = accept ? g_llx : tx;
  assign gy = accept ? g_lly : ty;

  // A group is last when its own advance would wrap past the top row.
  assign g_degen = (g_urx < g_llx) || (g_ury < g_lly);
  assign g_last  = g_degen ||
                   ((W'(gx) + span > W'(g_urx)) && (W'(gy) + W'(step) > W'(g_ury)));
  assign row_ok  = (gy <= g_ury);

  sample_lane_gen #(
    .SIGFIG  (SIGFIG),
    .SAMPLES (SAMPLES)
  ) u_lane_gen (
    .x0    (gx),
    .y     (gy),
    .step  (step),
    .ur_x  (g_urx),
    .pos   (lane_pos),
    .valid (lane_valid)
  );

  always_comb begin
    next_state = WAIT_STATE;
    if (emit && !g_last) next_state = TEST_STATE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= WAIT_STATE;
      halt_RnnnnL    <= 1'b1;
      box_q          <= '0;
      x0_q           <= '0;
      y_q            <= '0;
      tri_R14S       <= '0;
      color_R14U     <= '0;
      sample_R14S    <= '0;
      validSamp_R14H <= '0;
    end else begin
      state       <= next_state;
      halt_RnnnnL <= (next_state == WAIT_STATE);
      if (accept) begin
        box_q      <= box_R13S;
        tri_R14S   <= tri_R13S;
        color_R14U <= color_R13U;
      end
      if (emit) begin
        sample_R14S    <= lane_pos;
        validSamp_R14H <= row_ok ? lane_valid : '0;
        x0_q           <= gx;
        y_q            <= gy;
      end else begin
        validSamp_R14H <= '0;
      end
    end
  end

`ifdef SAMPLE_ITER_PERF_CNT_EN
  logic [31:0] run_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt         <= '0;
      iterCycles_R14U <= '0;
      iterTris_R14U   <= '0;
    end else begin
      if (accept && (iterTris_R14U != '1)) iterTris_R14U <= iterTris_R14U + 32'd1;
      if (emit) begin
        run_cnt <= accept ? 32'd1 : ((run_cnt == '1) ? run_cnt : run_cnt + 32'd1);
        if (g_last)
          iterCycles_R14U <= accept ? 32'd1 : ((run_cnt == '1) ? run_cnt : run_cnt + 32'd1);
      end
    end
  end
`endif

  a_subsample_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot(subSample_RnnnnU));

endmodule

// File: tb/tb_sample_iterator.sv
// tb/tb_sample_iterator.sv - randomized bbox walks checked against a row/column enumeration model
module tb_sample_iterator;

  localparam int SIGFIG  = 24;
  localparam int VERTS   = 3;
  localparam int AXIS    = 3;
  localparam int COLORS  = 3;
  localparam int SAMPLES = 2;
  localparam int N       = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_in, tri_out;
  logic        [COLORS-1:0][SIGFIG-1:0]          color_in, color_out;
  logic signed [1:0][1:0][SIGFIG-1:0]            box_in;
  logic                                          valid_tri;
  logic        [3:0]                             sub_sample;
  logic                                          halt;
  logic signed [SAMPLES-1:0][1:0][SIGFIG-1:0]    sample_out;
  logic        [SAMPLES-1:0]                     valid_samp;

  always #5 clk = ~clk;

  sample_iterator dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_in),
    .color_R13U       (color_in),
    .box_R13S         (box_in),
    .validTri_R13H    (valid_tri),
    .subSample_RnnnnU (sub_sample),
    .halt_RnnnnL      (halt),
    .tri_R14S         (tri_out),
    .color_R14U       (color_out),
    .sample_R14S      (sample_out),
    .validSamp_R14H   (valid_samp)
  );

  typedef struct {
    int               x;
    int               y;
    logic [SAMPLES-1:0] v;
  } grp_t;

  int errors = 0;
  int checks = 0;

  int         llx [N+2];
  int         lly [N+2];
  int         urx [N+2];
  int         ury [N+2];
  logic [3:0] sub_a [N+2];
  bit         held [N+2];
  int         idle [N+2];
  int         tri_a [N+2];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int step_of(input logic [3:0] s);
    if (s[3]) return 1024;
    if (s[2]) return 512;
    if (s[1]) return 256;
    return 128;
  endfunction

  task automatic drive(input int t);
    box_in[0][0] = SIGFIG'(llx[t]);
    box_in[0][1] = SIGFIG'(lly[t]);
    box_in[1][0] = SIGFIG'(urx[t]);
    box_in[1][1] = SIGFIG'(ury[t]);
    sub_sample   = sub_a[t];
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        tri_in[v][a] = SIGFIG'(tri_a[t] + v * 3 + a);
    for (int c = 0; c < COLORS; c++)
      color_in[c] = SIGFIG'(tri_a[t] + 100 + c);
    valid_tri = 1'b1;
  endtask

  // Enumerates rows bottom-up and column groups left-to-right; returns on the last group.
  task automatic expect_groups(input int t);
    grp_t q[$];
    int   st;
    st = step_of(sub_a[t]);
    if (urx[t] < llx[t] || ury[t] < lly[t]) begin
      grp_t g;
      g.x = llx[t];
      g.y = lly[t];
      g.v = '0;
      q.push_back(g);
    end else begin
      for (int y = lly[t]; y <= ury[t]; y += st)
        for (int x = llx[t]; x <= urx[t]; x += SAMPLES * st) begin
          grp_t g;
          g.x = x;
          g.y = y;
          for (int i = 0; i < SAMPLES; i++) g.v[i] = (x + i * st <= urx[t]);
          q.push_back(g);
        end
    end
    for (int k = 0; k < q.size(); k++) begin
      for (int i = 0; i < SAMPLES; i++)
        check($sformatf("t%0d g%0d x%0d", t, k, i), $signed(sample_out[i][0]), q[k].x + i * st);
      check($sformatf("t%0d g%0d y", t, k), $signed(sample_out[0][1]), q[k].y);
      check($sformatf("t%0d g%0d valid", t, k), valid_samp, q[k].v);
      check($sformatf("t%0d g%0d halt", t, k), halt, (k == q.size() - 1) ? 1 : 0);
      check($sformatf("t%0d g%0d tri", t, k), tri_out[1][2], tri_a[t] + 5);
      check($sformatf("t%0d g%0d color", t, k), color_out[2], tri_a[t] + 102);
      if (k < q.size() - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic set_tri(input int t, input int s, input int a, input int b, input int c, input int d,
                         input bit h, input int gap);
    sub_a[t] = 4'(s);
    llx[t] = a; lly[t] = b; urx[t] = c; ury[t] = d;
    held[t] = h;
    idle[t] = gap;
    tri_a[t] = int'($urandom_range(0, 1 << 20));
  endtask

  initial begin
    valid_tri  = 1'b0;
    sub_sample = 4'b1000;
    tri_in     = '0;
    color_in   = '0;
    box_in     = '0;

    set_tri(0, 8, 1024, 2048, 2048, 2048, 0, 1);
    set_tri(1, 8, 0, 0, 2048, 1024, 0, 0);
    set_tri(2, 4, 0, 0, 512, 512, 0, 0);
    set_tri(3, 4, -512, 0, 0, 512, 1, 2);
    set_tri(4, 8, 1024, 0, 0, 0, 0, 1);
    for (int t = 5; t < N; t++) begin
      bit h;
      int s, st, cols, rows;
      h = ($urandom_range(0, 2) == 0);
      s = h ? int'(sub_a[t-1]) : (1 << $urandom_range(0, 3));
      st = step_of(4'(s));
      cols = int'($urandom_range(0, 5)) - ($urandom_range(0, 6) == 0 ? 2 : 0);
      rows = int'($urandom_range(0, 3)) - ($urandom_range(0, 6) == 0 ? 2 : 0);
      set_tri(t, s, (int'($urandom_range(0, 8)) - 4) * st, (int'($urandom_range(0, 8)) - 4) * st,
              0, 0, h, $urandom_range(0, 2));
      urx[t] = llx[t] + cols * st;
      ury[t] = lly[t] + rows * st;
    end
    set_tri(N, 8, 0, 0, 2048, 1024, 0, 0);
    set_tri(N + 1, 2, 512, -1024, 1024, -768, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset halt", halt, 1);
    check("reset valid", valid_samp, 0);
    check("reset sample", sample_out[1][0], 0);
    check("reset tri", tri_out[0][0], 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    drive(0);
    for (int t = 0; t < N; t++) begin
      @(posedge clk);
      #1;
      if (t + 1 < N && held[t+1]) drive(t + 1);
      else valid_tri = 1'b0;
      expect_groups(t);
      if (t + 1 < N && !held[t+1]) begin
        repeat (idle[t]) begin
          @(posedge clk);
          #1;
          check($sformatf("t%0d idle valid", t), valid_samp, 0);
          check($sformatf("t%0d idle halt", t), halt, 1);
        end
        drive(t + 1);
      end
    end
    valid_tri = 1'b0;
    @(posedge clk);
    #1;
    check("post valid", valid_samp, 0);

    drive(N);
    @(posedge clk);
    #1;
    valid_tri = 1'b0;
    check("abort g0 valid", valid_samp, 2'b11);
    @(posedge clk);
    #1;
    check("abort g1 halt", halt, 0);
    #2;
    rst = 1'b0;
    #1;
    check("abort async halt", halt, 1);
    check("abort async valid", valid_samp, 0);
    check("abort async sample", sample_out[1][0], 0);
    check("abort async tri", tri_out[1][2], 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("after release valid", valid_samp, 0);
    check("after release halt", halt, 1);
    drive(N + 1);
    @(posedge clk);
    #1;
    valid_tri = 1'b0;
    expect_groups(N + 1);
    @(posedge clk);
    #1;
    check("final valid", valid_samp, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
